// File: rtl/axil_reg_bridge_pkg.sv
// Shared types and constants for the AXI4-Lite to register-bus bridge.
// Response codes follow AXI4-Lite encoding.
package axil_reg_bridge_pkg;

  localparam int REG_ADDR_W = 14;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_WAIT,
    WR_RESP,
    RD_REQ,
    RD_WAIT,
    RD_RESP
  } bridge_state_t;

endpackage

// File: rtl/axil_timeout_counter.sv
// Ack timeout counter: cleared by load, counts while enabled and
// saturates at the terminal count TIMEOUT_CYCLES-1.
module axil_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic enable,
  output logic tc
);

  localparam logic [7:0] LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] cnt;

  assign tc = (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (enable && !tc) begin
      cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/axil_reg_bridge.sv
// AXI4-Lite slave that turns each write/read into one register-bus
// request, waits for ack/err/timeout and returns the AXI response.
module axil_reg_bridge
  import axil_reg_bridge_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 16,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                      axi_clk,
  input  logic                      axi_rst,
  input  logic [AXI_ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic                      s_axi_awvalid,
  output logic                      s_axi_awready,
  input  logic [31:0]               s_axi_wdata,
  input  logic [3:0]                s_axi_wstrb,
  input  logic                      s_axi_wvalid,
  output logic                      s_axi_wready,
  output logic [1:0]                s_axi_bresp,
  output logic                      s_axi_bvalid,
  input  logic                      s_axi_bready,
  input  logic [AXI_ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic                      s_axi_arvalid,
  output logic                      s_axi_arready,
  output logic [31:0]               s_axi_rdata,
  output logic [1:0]                s_axi_rresp,
  output logic                      s_axi_rvalid,
  input  logic                      s_axi_rready,
  output logic                      axi_wreq,
  output logic [REG_ADDR_W-1:0]     axi_waddr,
  output logic [31:0]               axi_wdata,
  input  logic                      axi_wack,
  input  logic                      axi_werr,
  output logic                      axi_rreq,
  output logic [REG_ADDR_W-1:0]     axi_raddr,
  input  logic [31:0]               axi_rdata,
  input  logic                      axi_rack,
  input  logic                      axi_rerr
);

  bridge_state_t state, state_n;

  logic aw_full, w_full, ar_full;
  logic aw_full_n, w_full_n, ar_full_n;
  logic [3:0] wstrb_q;
  logic aw_hs, w_hs, ar_hs, b_hs, r_hs;
  logic wr_rdy, rd_rdy, wr_pick, strb_ok;
  logic prio_wr;
  logic cnt_load, cnt_en, tc;
  logic bresp_we, rresp_we;
  logic [1:0] resp_n;
  logic [31:0] rdata_n;
  logic unused_bits;

  assign unused_bits = ^{s_axi_awaddr, s_axi_araddr};

  assign aw_hs = s_axi_awvalid & s_axi_awready;
  assign w_hs  = s_axi_wvalid & s_axi_wready;
  assign ar_hs = s_axi_arvalid & s_axi_arready;
  assign b_hs  = s_axi_bvalid & s_axi_bready;
  assign r_hs  = s_axi_rvalid & s_axi_rready;

  assign aw_full_n = aw_hs | (aw_full & !b_hs);
  assign w_full_n  = w_hs | (w_full & !b_hs);
  assign ar_full_n = ar_hs | (ar_full & !r_hs);

  // Handshakes in flight count as held, saving a cycle of latency.
  assign wr_rdy  = (aw_full | aw_hs) & (w_full | w_hs);
  assign rd_rdy  = ar_full | ar_hs;
  assign wr_pick = wr_rdy & (!rd_rdy | prio_wr);
  assign strb_ok = ((w_hs ? s_axi_wstrb : wstrb_q) == 4'hF);

  always_ff @(posedge axi_clk or posedge axi_rst) begin
    if (axi_rst) begin
      aw_full       <= 1'b0;
      w_full        <= 1'b0;
      ar_full       <= 1'b0;
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_arready <= 1'b0;
      axi_waddr     <= '0;
      axi_wdata     <= '0;
      axi_raddr     <= '0;
      wstrb_q       <= '0;
    end else begin
      aw_full       <= aw_full_n;
      w_full        <= w_full_n;
      ar_full       <= ar_full_n;
      s_axi_awready <= !aw_full_n;
      s_axi_wready  <= !w_full_n;
      s_axi_arready <= !ar_full_n;
      if (aw_hs) axi_waddr <= s_axi_awaddr[15:2];
      if (ar_hs) axi_raddr <= s_axi_araddr[15:2];
      if (w_hs) begin
        axi_wdata <= s_axi_wdata;
        wstrb_q   <= s_axi_wstrb;
      end
    end
  end

  // Counting starts with the request cycle, so DECERR is returned
  // TIMEOUT_CYCLES cycles after the request pulse.
  axil_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_tmo (
    .clk   (axi_clk),
    .rst   (axi_rst),
    .load  (cnt_load),
    .enable(cnt_en),
    .tc    (tc)
  );

  always_comb begin
    state_n      = state;
    cnt_load     = 1'b0;
    cnt_en       = 1'b0;
    bresp_we     = 1'b0;
    rresp_we     = 1'b0;
    resp_n       = RESP_OKAY;
    rdata_n      = '0;
    axi_wreq     = 1'b0;
    axi_rreq     = 1'b0;
    s_axi_bvalid = 1'b0;
    s_axi_rvalid = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_load = 1'b1;
        if (wr_pick) begin
          if (strb_ok) begin
            state_n = WR_REQ;
          end else begin
            state_n  = WR_RESP;
            bresp_we = 1'b1;
            resp_n   = RESP_SLVERR;
          end
        end else if (rd_rdy) begin
          state_n = RD_REQ;
        end
      end
      WR_REQ: begin
        axi_wreq = 1'b1;
        cnt_en   = 1'b1;
        state_n  = WR_WAIT;
      end
      WR_WAIT: begin
        cnt_en = 1'b1;
        if (axi_wack) begin
          state_n  = WR_RESP;
          bresp_we = 1'b1;
          resp_n   = axi_werr ? RESP_SLVERR : RESP_OKAY;
        end else if (tc) begin
          state_n  = WR_RESP;
          bresp_we = 1'b1;
          resp_n   = RESP_DECERR;
        end
      end
      WR_RESP: begin
        s_axi_bvalid = 1'b1;
        if (s_axi_bready) state_n = IDLE;
      end
      RD_REQ: begin
        axi_rreq = 1'b1;
        cnt_en   = 1'b1;
        state_n  = RD_WAIT;
      end
      RD_WAIT: begin
        cnt_en = 1'b1;
        if (axi_rack) begin
          state_n  = RD_RESP;
          rresp_we = 1'b1;
          resp_n   = axi_rerr ? RESP_SLVERR : RESP_OKAY;
          rdata_n  = axi_rerr ? 32'h0 : axi_rdata;
        end else if (tc) begin
          state_n  = RD_RESP;
          rresp_we = 1'b1;
          resp_n   = RESP_DECERR;
        end
      end
      RD_RESP: begin
        s_axi_rvalid = 1'b1;
        if (s_axi_rready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge axi_clk or posedge axi_rst) begin
    if (axi_rst) begin
      state       <= IDLE;
      prio_wr     <= 1'b1;
      s_axi_bresp <= RESP_OKAY;
      s_axi_rresp <= RESP_OKAY;
      s_axi_rdata <= '0;
    end else begin
      state <= state_n;
      if (b_hs) prio_wr <= 1'b0;
      else if (r_hs) prio_wr <= 1'b1;
      if (bresp_we) s_axi_bresp <= resp_n;
      if (rresp_we) begin
        s_axi_rresp <= resp_n;
        s_axi_rdata <= rdata_n;
      end
    end
  end

endmodule

// File: doc/axil_reg_bridge.md
Name: axil_reg_bridge

Overview:
- AXI4-Lite slave to simple register-bus initiator, sitting between the interconnect and register-bank responders.
- Converts each AXI4-Lite write or read into a single-cycle request on the register bus, then waits for the ack.
- Converts ack, err or timeout into the AXI response.
- One transaction is outstanding at a time.

Parameters:
AXI_ADDR_WIDTH, 16, s_axi byte-address width; must be >= 16 (register word address is bits [15:2]).
TIMEOUT_CYCLES, 16, cycles to wait for ack after the request pulse before returning DECERR; range 2..255.

Ports:
axi_clk  in  1  clock
axi_rst  in  1  asynchronous active-high reset; one clock; reset is asynchronous and active-high
s_axi_awaddr  in  AXI_ADDR_WIDTH  write byte address
s_axi_awvalid/s_axi_awready  in/out  1  AW handshake
s_axi_wdata  in  32  write data
s_axi_wstrb  in  4  byte strobes
s_axi_wvalid/s_axi_wready  in/out  1  W handshake
s_axi_bresp  out  2  write response
s_axi_bvalid/s_axi_bready  out/in  1  B handshake
s_axi_araddr  in  AXI_ADDR_WIDTH  read byte address
s_axi_arvalid/s_axi_arready  in/out  1  AR handshake
s_axi_rdata  out  32  read data
s_axi_rresp  out  2  read response
s_axi_rvalid/s_axi_rready  out/in  1  R handshake
axi_wreq  out  1  register write request pulse
axi_waddr  out  14  word address = awaddr[15:2]
axi_wdata  out  32  write data
axi_wack, axi_werr  in  1  write ack / error
axi_rreq  out  1  register read request pulse
axi_raddr  out  14  word address = araddr[15:2]
axi_rdata  in  32  read data, valid with axi_rack
axi_rack, axi_rerr  in  1  read ack / error

Behaviour:
- Reset values: all ready, valid and req outputs 0; bresp, rresp, rdata, waddr, raddr, wdata 0; FSM IDLE; holding flags empty; priority = write.
- Holding registers: AW, W and AR are each captured independently.
  - awready = !aw_full; wready = !w_full; arready = !ar_full (all registered).
  - aw_full and w_full clear on the B handshake; ar_full clears on the R handshake.
- FSM states: IDLE, WR_REQ, WR_WAIT, WR_RESP, RD_REQ, RD_WAIT, RD_RESP.
- IDLE:
  - Write is ready when aw_full & w_full; read is ready when ar_full.
  - If both are ready, take the op opposite to the last completed op.
  - If wstrb != 4'hF: skip the bus and go to WR_RESP with SLVERR (2'b10).
- WR_REQ / RD_REQ: req = 1 for exactly one cycle, with addr/data already driven and stable. Next state is *_WAIT and the timeout counter loads 0.
- *_WAIT: addr/data held stable; counter increments each cycle.
  - ack & !err -> OKAY (2'b00).
  - ack & err -> SLVERR.
  - Counter == TIMEOUT_CYCLES-1 with no ack -> DECERR (2'b11).
  - On read: capture axi_rdata on OKAY; rdata = 0 on any error.
- *_RESP: bvalid/rvalid = 1 and held with bresp/rresp/rdata stable until ready; then go to IDLE.
- Acks arriving outside *_WAIT (late or duplicate) are ignored.
- Ack in the same cycle as the timeout terminal count: the ack wins.
- Latency to bvalid with a responder that acks the cycle after the request: AW+W accepted at T, req at T+1 (WR_REQ entered at T+1), ack at T+2, bvalid at T+3.
- Reset asserted mid-operation: the FSM returns to IDLE immediately and the pending transaction is dropped without a response; req deasserts asynchronously.

Decomposition:
- Package axil_reg_bridge_pkg:
  - state enum (bridge_state_t).
  - RESP_OKAY/RESP_SLVERR/RESP_DECERR localparams.
  - REG_ADDR_W = 14.
- One sub-module, axil_timeout_counter (load, enable, terminal-count out, TIMEOUT_CYCLES param), shared with future bridges.

Test Plan:
- Write 0xDEADBEEF to 0x2004, wstrb F, bench responder acks after 1 cycle -> one-cycle axi_wreq with waddr 14'h0801, wdata DEADBEEF; bresp 00.
- Read 0x2004 after that write -> axi_rreq pulse, raddr 14'h0801; rdata 0xDEADBEEF, rresp 00; bridge holds rvalid while rready is held 0 for 5 cycles.
- Write 0x2010 with responder returning wack+werr -> bresp 10. Write with wstrb 4'h3 -> bresp 10 and no axi_wreq.
- Read 0x0000, responder silent -> rvalid exactly 16 cycles after the axi_rreq cycle; rresp 11, rdata 0; a late rack 3 cycles later is ignored.
- AW, W and AR presented in the same cycle -> write issued first, then read; both responses correct; W before AW by 4 cycles still pairs correctly.
- axi_rst pulsed during WR_WAIT -> all outputs reset the same cycle; next write 0x2008 completes with OKAY.
